joy_poll_scheduler: RTL and testbench
=====================================

# joy_poll_scheduler

Sequencer and arbiter that owns the byte-wide register bus of `N64_controller_top` and drives all traffic on it. It periodically polls every enabled joy port with the button-read command (0x01) and latches 32-bit button words plus per-port alive flags. An optional host path shares the same bus for one-shot status (0x00) or reset (0xFF) commands. It sits between the PIF command logic and `N64_controller_top`.

## Interface
- `POLL_INTERVAL`, default 16'd50000: idle cycles between the end of one poll round and the start of the next.
- `TIMEOUT`, default 16'd4095: number of status polls without a ready indication before a port is declared dead.
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-high reset.
- `port_en` input 4: per-port poll enable, bit n = joy(n+1); sampled when a round starts.
- `address` output 4: register address to `N64_controller_top`.
- `data_in_bus` output 8: write data to `N64_controller_top`.
- `write` output 1: write strobe; valid only with `ce`.
- `ce` output 1: bus access strobe.
- `data_out_bus` input 8: read data from `N64_controller_top`; valid on the cycle after a read access.
- `buttons` output 128: `[32n+31:32n]` holds port n's button word, bit map per the controller layout (A = bit 0, Y axis = bits 31:24).
- `alive` output 4: port n answered its last poll.
- `round_done` output 1: one-cycle pulse at the end of each poll round.
- `host_req` input 1 (`JOY_POLL_HOST_EN` only): request; held until `host_gnt`.
- `host_cmd` input 8: 0x00 or 0xFF; any other value is treated as 0x00.
- `host_port` input 2: target port.
- `host_gnt` output 1: one-cycle accept pulse.
- `host_done` output 1: one-cycle completion pulse.
- `host_resp` output 24: status bytes, with byte 0 in bits 7:0.
- `host_err` output 1: valid with `host_done`; 1 means timeout.

## Operation
- Register map:
  - 0x0 = cmd
  - 0x3 = status: bit0 ready, bit1 no-response
  - 0x4 = control: one-hot port bits 3:0 start a transaction
  - 0x5 = read FIFO, one byte per read
- Bus access rules:
  - Each access lasts exactly one cycle with `ce`=1.
  - Outside an access, `ce`=`write`=0, `address`=0, `data_in_bus`=0.
- States and transitions:
  - IDLE: wait for the interval counter to expire, or for a pending host request.
  - SELECT: choose the next port. Host requests have priority at round boundaries only; a host transaction never splits a poll round. Otherwise take the lowest enabled port above the last serviced one. If no enabled port remains, pulse `round_done` and go to IDLE.
  - WR_CMD: write the command to 0x0.
  - WR_CTRL: write the one-hot port to 0x4.
  - RD_STAT: read 0x3.
  - CHK_STAT:
    - bit0=1 → go to RD_FIFO.
    - bit1=1, or `TIMEOUT` polls exhausted → port dead: `alive[n]`=0, `buttons` for that port unchanged.
    - otherwise → back to RD_STAT.
  - RD_FIFO: read 4 bytes for a poll or 3 bytes for a status command; no bytes for a reset command.
  - COMMIT: write the assembled word to the port's `buttons` slot and set `alive[n]`=1 together in one cycle. For a host command, pulse `host_done` instead.
- Rounds:
  - `port_en` changes mid-round take effect at the next round.
  - If all ports are disabled, a round completes immediately with a `round_done` pulse.

## Timing
- Reset values: every output is 0, the state is IDLE, and the interval counter is loaded with `POLL_INTERVAL`.
- Reset mid-transaction aborts immediately; the bus returns to idle on the same reset assertion.
- Read data is captured at cycle N+1 for an access at cycle N; a new read access may issue at N+1.
- Minimum poll latency per port: 2 writes + 2 cycles per status read + 2 cycles per FIFO byte + 1 commit cycle.
- Interval counting:
  - The counter restarts on the `round_done` cycle.
  - `POLL_INTERVAL`=0 means back-to-back rounds.
- Timeout counting:
  - The counter counts status reads and reloads per port.
  - `TIMEOUT`=0 means a single status read decides.
- Host handshake:
  - `host_gnt` is asserted in the SELECT cycle that takes the request.
  - `host_req` is ignored while a transaction is active or while `host_gnt` is high.

## Configuration
- `JOY_POLL_HOST_EN` defined: host ports exist, and host requests are arbitrated as described.
- Not defined:
  - The host ports are absent.
  - The scheduler only polls.
  - The SELECT host branch is removed.

## Structure
- Package `joy_poll_pkg` holds:
  - the register address constants (0x0, 0x3, 0x4, 0x5);
  - the command codes (0x00, 0x01, 0xFF);
  - the status bit indices;
  - the state enum.
- Sub-module `joy_poll_timer`: a 16-bit loadable down-counter with a zero flag, instantiated twice (interval and timeout).

## Test plan
- Single port, button read: `port_en`=0001, controller returns bytes 10,00,05,04 → `buttons[31:0]`=0x0405_0010, `alive`=0001, exactly one `round_done` pulse.
- Round-robin order: `port_en`=1010 → ports 1 then 3 are serviced; the bus writes 0x02 then 0x08 to address 0x4.
- Dead port: status bit1=1 for port 2 → `alive[2]`=0, `buttons[95:64]` keeps its previous value, and the round continues to port 3.
- Timeout: status stays 0 with `TIMEOUT`=3 → exactly 4 reads of 0x3, then `alive`=0 for that port.
- Host priority: `host_req` with `host_cmd`=0x00 raised mid-round → it is granted only after `round_done`; `host_resp`=0x000105 (bytes 05,01,00), `host_err`=0.
- Reset mid-read: `reset` asserted during RD_FIFO → `ce`=0 and all outputs 0 immediately; after release, the first access happens `POLL_INTERVAL` cycles later.

Source files
------------

// File: rtl/joy_poll_pkg.sv
// Shared constants for the joy poll scheduler: register map of
// N64_controller_top, command codes, status bit positions and the FSM states.
package joy_poll_pkg;
  localparam logic [3:0] REG_CMD    = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h3;
  localparam logic [3:0] REG_CTRL   = 4'h4;
  localparam logic [3:0] REG_FIFO   = 4'h5;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam int STAT_READY  = 0;
  localparam int STAT_NORESP = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_WR_CMD, ST_WR_CTRL,
    ST_RD_STAT, ST_CHK_STAT, ST_RD_FIFO, ST_COMMIT
  } state_t;
endpackage

// File: rtl/joy_poll_timer.sv
// 16-bit loadable down-counter with zero flag. Saturates at zero.
// Ports: clk, rst (async high), load/load_val reload, dec decrement, zero flag.
module joy_poll_timer #(
  parameter logic [15:0] RESET_VAL = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count_q <= RESET_VAL;
    else if (load)                 count_q <= load_val;
    else if (dec && count_q != '0) count_q <= count_q - 16'd1;
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/joy_poll_scheduler.sv
// Owns the register bus of N64_controller_top. Polls every enabled port with
// the button-read command once per round and latches button words / alive
// flags. Optional host path (macro JOY_POLL_HOST_EN) issues one-shot status
// or reset commands between rounds.
// Ports: clk/reset; port_en; bus (address, data_in_bus, write, ce,
// data_out_bus); buttons, alive, round_done; host_* when JOY_POLL_HOST_EN.
module joy_poll_scheduler
  import joy_poll_pkg::*;
#(
  parameter logic [15:0] POLL_INTERVAL = 16'd50000,
  parameter logic [15:0] TIMEOUT       = 16'd4095
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   port_en,
  output logic [3:0]   address,
  output logic [7:0]   data_in_bus,
  output logic         write,
  output logic         ce,
  input  logic [7:0]   data_out_bus,
  output logic [127:0] buttons,
  output logic [3:0]   alive,
  output logic         round_done
`ifdef JOY_POLL_HOST_EN
  ,
  input  logic         host_req,
  input  logic [7:0]   host_cmd,
  input  logic [1:0]   host_port,
  output logic         host_gnt,
  output logic         host_done,
  output logic [23:0]  host_resp,
  output logic         host_err
`endif
);
  state_t      state_q, state_d;
  logic        in_round_q, is_host_q, dead_q, phase_q;
  logic [3:0]  en_q;
  logic [1:0]  port_q, byte_idx_q, nxt_port, last_idx;
  logic [7:0]  cmd_q;
  logic [31:0] word_q;
  logic [3:0]  mask;
  logic        found, host_sel, int_zero, to_zero;
  logic        st_ready, st_noresp, retry;

  // Host only wins at a round boundary; inside a round it is invisible.
`ifdef JOY_POLL_HOST_EN
  assign host_sel = host_req && !in_round_q;
`else
  assign host_sel = 1'b0;
`endif

  // First SELECT of a round works from live port_en; later ones from the snapshot.
  assign mask = in_round_q ? en_q : port_en;
  always_comb begin
    found    = 1'b0;
    nxt_port = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (!in_round_q || i > int'(port_q))) begin
        found    = 1'b1;
        nxt_port = 2'(i);
      end
    end
  end

  assign st_ready  = data_out_bus[STAT_READY];
  assign st_noresp = data_out_bus[STAT_NORESP];
  assign retry     = (state_q == ST_CHK_STAT) && !st_ready && !st_noresp && !to_zero;
  assign last_idx  = (cmd_q == CMD_POLL) ? 2'd3 : 2'd2;

  joy_poll_timer #(.RESET_VAL(POLL_INTERVAL)) u_interval (
    .clk(clk), .rst(reset), .load(round_done), .load_val(POLL_INTERVAL),
    .dec(1'b1), .zero(int_zero)
  );

  joy_poll_timer #(.RESET_VAL(TIMEOUT)) u_timeout (
    .clk(clk), .rst(reset), .load(state_q == ST_WR_CTRL), .load_val(TIMEOUT),
    .dec(retry), .zero(to_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (host_sel || int_zero) state_d = ST_SELECT;
      ST_SELECT:   state_d = (host_sel || found) ? ST_WR_CMD : ST_IDLE;
      ST_WR_CMD:   state_d = ST_WR_CTRL;
      ST_WR_CTRL:  state_d = ST_RD_STAT;
      ST_RD_STAT:  state_d = ST_CHK_STAT;
      ST_CHK_STAT: begin
        if (st_ready)               state_d = (cmd_q == CMD_RESET) ? ST_COMMIT : ST_RD_FIFO;
        else if (st_noresp || to_zero) state_d = ST_COMMIT;
        else                        state_d = ST_RD_STAT;
      end
      ST_RD_FIFO:  if (phase_q && byte_idx_q == last_idx) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = is_host_q ? ST_IDLE : ST_SELECT;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Bus is purely a function of state so an async reset idles it at once.
  always_comb begin
    ce          = 1'b0;
    write       = 1'b0;
    address     = '0;
    data_in_bus = '0;
    round_done  = (state_q == ST_SELECT) && !host_sel && !found;
    unique case (state_q)
      ST_WR_CMD:  begin ce = 1'b1; write = 1'b1; address = REG_CMD; data_in_bus = cmd_q; end
      ST_WR_CTRL: begin ce = 1'b1; write = 1'b1; address = REG_CTRL;
                        data_in_bus = {4'b0, 4'b0001 << port_q}; end
      ST_RD_STAT: begin ce = 1'b1; address = REG_STATUS; end
      ST_RD_FIFO: if (!phase_q) begin ce = 1'b1; address = REG_FIFO; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_round_q <= 1'b0; is_host_q <= 1'b0; dead_q <= 1'b0; phase_q <= 1'b0;
      en_q <= '0; port_q <= '0; byte_idx_q <= '0; cmd_q <= '0; word_q <= '0;
      buttons <= '0; alive <= '0;
    end else begin
      unique case (state_q)
        ST_SELECT: begin
          if (host_sel) begin
`ifdef JOY_POLL_HOST_EN
            is_host_q <= 1'b1;
            port_q    <= host_port;
            cmd_q     <= (host_cmd == CMD_RESET) ? CMD_RESET : CMD_STATUS;
`endif
          end else if (found) begin
            if (!in_round_q) en_q <= port_en;
            in_round_q <= 1'b1;
            is_host_q  <= 1'b0;
            port_q     <= nxt_port;
            cmd_q      <= CMD_POLL;
          end else begin
            in_round_q <= 1'b0;
          end
        end
        ST_WR_CMD: begin
          word_q <= '0; byte_idx_q <= '0; phase_q <= 1'b0; dead_q <= 1'b0;
        end
        ST_CHK_STAT:
          if (!st_ready && (st_noresp || to_zero)) dead_q <= 1'b1;
        ST_RD_FIFO: begin
          // phase 0 issues the read, phase 1 captures the returned byte
          phase_q <= !phase_q;
          if (phase_q) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= data_out_bus;
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        ST_COMMIT:
          if (!is_host_q) begin
            if (dead_q) alive[port_q] <= 1'b0;
            else begin
              buttons[{port_q, 5'b00000} +: 32] <= word_q;
              alive[port_q] <= 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

`ifdef JOY_POLL_HOST_EN
  assign host_gnt = (state_q == ST_SELECT) && host_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_done <= 1'b0; host_resp <= '0; host_err <= 1'b0;
    end else begin
      host_done <= 1'b0;
      if (state_q == ST_COMMIT && is_host_q) begin
        host_done <= 1'b1;
        host_resp <= word_q[23:0];
        host_err  <= dead_q;
      end
    end
  end
`endif
endmodule

// File: tb/tb_joy_poll_scheduler.sv
module tb_joy_poll_scheduler;
  localparam int P = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   port_en = 4'b0000;
  logic [3:0]   address;
  logic [7:0]   data_in_bus;
  logic         write, ce;
  logic [7:0]   data_out_bus = 8'h00;
  logic [127:0] buttons;
  logic [3:0]   alive;
  logic         round_done;
`ifdef JOY_POLL_HOST_EN
  logic         host_req = 1'b0;
  logic [7:0]   host_cmd = 8'h00;
  logic [1:0]   host_port = 2'd0;
  logic         host_gnt, host_done, host_err;
  logic [23:0]  host_resp;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  joy_poll_scheduler #(.POLL_INTERVAL(16'd20), .TIMEOUT(16'd3)) dut (
    .clk(clk), .reset(reset), .port_en(port_en), .address(address),
    .data_in_bus(data_in_bus), .write(write), .ce(ce), .data_out_bus(data_out_bus),
    .buttons(buttons), .alive(alive), .round_done(round_done)
`ifdef JOY_POLL_HOST_EN
    , .host_req(host_req), .host_cmd(host_cmd), .host_port(host_port),
    .host_gnt(host_gnt), .host_done(host_done), .host_resp(host_resp), .host_err(host_err)
`endif
  );

  // Controller model: mode 0 ready after ready_after reads, 1 no-response, 2 never ready
  logic [1:0] mode [4];
  int         ready_after [4];
  logic [7:0] fbytes [4][4];
  int         cur = 0, sc = 0, fi = 0;
  int         stat_reads [4] = '{default: 0};
  logic [7:0] ctrl_log [$];
  logic [7:0] cmd_log [$];

  function automatic int onehot_idx(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    if (ce && write) begin
      if (address == 4'h4) begin
        ctrl_log.push_back(data_in_bus);
        cur <= onehot_idx(data_in_bus);
        sc  <= 0;
        fi  <= 0;
      end else if (address == 4'h0) cmd_log.push_back(data_in_bus);
    end else if (ce && !write) begin
      if (address == 4'h3) begin
        stat_reads[cur] <= stat_reads[cur] + 1;
        sc <= sc + 1;
        case (mode[cur])
          2'd0:    data_out_bus <= (sc >= ready_after[cur]) ? 8'h01 : 8'h00;
          2'd1:    data_out_bus <= 8'h02;
          default: data_out_bus <= 8'h00;
        endcase
      end else if (address == 4'h5) begin
        data_out_bus <= fbytes[cur][fi & 3];
        fi <= fi + 1;
      end
    end
  end

  task automatic wait_rd(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (round_done !== 1'b1 && n < 400);
    vectors++;
    if (round_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: round_done not seen within %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({ce, write, address, data_in_bus, round_done} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got ce=%b wr=%b addr=%h d=%h rd=%b, want all 0",
               ce, write, address, data_in_bus, round_done);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (buttons !== 128'd0 || alive !== 4'd0 || ce !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: buttons=%h alive=%b ce=%b, want 0", buttons, alive, ce);
    end
  endtask

  task automatic test_single_port();
    int c0, extra;
    mode[0] = 2'd0; ready_after[0] = 1;
    fbytes[0] = '{8'h10, 8'h00, 8'h05, 8'h04};
    wait_rd("single_pre");
    port_en = 4'b0001;
    c0 = ctrl_log.size();
    wait_rd("single_round");
    vectors++;
    if (buttons[31:0] !== 32'h0405_0010) begin
      miscompares++;
      $display("FAIL single_buttons: got %h want 04050010", buttons[31:0]);
    end
    vectors++;
    if (alive !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_alive: got %b want 0001", alive);
    end
    vectors++;
    if (ctrl_log.size() != c0 + 1 || ctrl_log[c0] !== 8'h01 || cmd_log[cmd_log.size()-1] !== 8'h01) begin
      miscompares++;
      $display("FAIL single_bus: ctrl writes=%0d want 1, last cmd=%h want 01",
               ctrl_log.size() - c0, cmd_log[cmd_log.size()-1]);
    end
    extra = 0;
    repeat (10) begin @(negedge clk); if (round_done) extra++; end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL single_round_done: got %0d pulses want 1", extra + 1);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    mode[1] = 2'd0; ready_after[1] = 0; fbytes[1] = '{8'h11, 8'h22, 8'h33, 8'h44};
    mode[3] = 2'd0; ready_after[3] = 0; fbytes[3] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    port_en = 4'b1010;
    wait_rd("rr_pre");
    c0 = ctrl_log.size();
    wait_rd("rr_round");
    vectors++;
    if (ctrl_log.size() != c0 + 2 || ctrl_log[c0] !== 8'h02 || ctrl_log[c0+1] !== 8'h08) begin
      miscompares++;
      $display("FAIL rr_order: %0d ctrl writes, want 02 then 08", ctrl_log.size() - c0);
    end
    vectors++;
    if (buttons[63:32] !== 32'h4433_2211 || buttons[127:96] !== 32'hD4C3_B2A1) begin
      miscompares++;
      $display("FAIL rr_buttons: p1=%h want 44332211 p3=%h want d4c3b2a1",
               buttons[63:32], buttons[127:96]);
    end
    vectors++;
    if (alive !== 4'b1011) begin
      miscompares++;
      $display("FAIL rr_alive: got %b want 1011", alive);
    end
  endtask

  task automatic test_dead_port();
    int c0;
    mode[2] = 2'd0; ready_after[2] = 0; fbytes[2] = '{8'h01, 8'h02, 8'h03, 8'h04};
    port_en = 4'b0100;
    wait_rd("dead_pre");
    wait_rd("dead_good_round");
    vectors++;
    if (buttons[95:64] !== 32'h0403_0201 || alive !== 4'b1111) begin
      miscompares++;
      $display("FAIL dead_setup: p2=%h want 04030201 alive=%b want 1111", buttons[95:64], alive);
    end
    mode[2] = 2'd1;
    fbytes[3] = '{8'h01, 8'h5A, 8'h00, 8'h80};
    port_en = 4'b1100;
    c0 = ctrl_log.size();
    wait_rd("dead_round");
    vectors++;
    if (alive !== 4'b1011 || buttons[95:64] !== 32'h0403_0201) begin
      miscompares++;
      $display("FAIL dead_port: alive=%b want 1011 p2=%h want 04030201", alive, buttons[95:64]);
    end
    vectors++;
    if (ctrl_log.size() != c0 + 2 || ctrl_log[c0+1] !== 8'h08 || buttons[127:96] !== 32'h8000_5A01) begin
      miscompares++;
      $display("FAIL dead_continue: p3=%h want 80005a01 ctrl writes=%0d want 2",
               buttons[127:96], ctrl_log.size() - c0);
    end
  endtask

  task automatic test_timeout();
    int base;
    mode[1] = 2'd2;
    port_en = 4'b0010;
    wait_rd("to_pre");
    base = stat_reads[1];
    wait_rd("to_round");
    vectors++;
    if (stat_reads[1] - base != 4) begin
      miscompares++;
      $display("FAIL timeout_reads: got %0d status reads want 4", stat_reads[1] - base);
    end
    vectors++;
    if (alive !== 4'b1001 || buttons[63:32] !== 32'h4433_2211) begin
      miscompares++;
      $display("FAIL timeout_alive: alive=%b want 1001 p1=%h want 44332211", alive, buttons[63:32]);
    end
  endtask

`ifdef JOY_POLL_HOST_EN
  task automatic test_host_priority();
    int n;
    bit rd_seen;
    mode[2] = 2'd0; ready_after[2] = 0; fbytes[2] = '{8'h05, 8'h01, 8'h00, 8'h00};
    port_en = 4'b0001;
    wait_rd("host_pre");
    n = 0;
    do begin @(negedge clk); n++; end while (!(ce && write && address == 4'h4) && n < 400);
    host_cmd = 8'h00; host_port = 2'd2; host_req = 1'b1;
    rd_seen = 0; n = 0;
    while (host_gnt !== 1'b1 && n < 400) begin
      @(negedge clk); n++;
      if (round_done) rd_seen = 1;
    end
    host_req = 1'b0;
    vectors++;
    if (host_gnt !== 1'b1 || !rd_seen) begin
      miscompares++;
      $display("FAIL host_grant: gnt=%b round_done_before=%0d want 1/1", host_gnt, rd_seen);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (host_done !== 1'b1 && n < 400);
    vectors++;
    if (host_done !== 1'b1 || host_resp !== 24'h000105 || host_err !== 1'b0) begin
      miscompares++;
      $display("FAIL host_resp: done=%b resp=%h err=%b want 1/000105/0", host_done, host_resp, host_err);
    end
    vectors++;
    if (cmd_log[cmd_log.size()-1] !== 8'h00 || ctrl_log[ctrl_log.size()-1] !== 8'h04 || alive !== 4'b1001) begin
      miscompares++;
      $display("FAIL host_bus: cmd=%h want 00 ctrl=%h want 04 alive=%b want 1001",
               cmd_log[cmd_log.size()-1], ctrl_log[ctrl_log.size()-1], alive);
    end
  endtask
`endif

  task automatic test_reset_mid_read();
    int n;
    bit early;
    port_en = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (!(ce && !write && address == 4'h5) && n < 400);
    vectors++;
    if (!(ce && !write && address == 4'h5)) begin
      miscompares++;
      $display("FAIL rst_mid_find: no FIFO read seen, ce=%b addr=%h", ce, address);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ce, write, address, data_in_bus, round_done} !== 15'd0 || buttons !== 128'd0 || alive !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: ce=%b addr=%h buttons=%h alive=%b want all 0",
               ce, address, buttons, alive);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    early = 0;
    repeat (P) begin @(negedge clk); if (ce) early = 1; end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL rst_mid_interval: access within %0d cycles of release, want none", P);
    end
    n = 0;
    while (ce !== 1'b1 && n < 6) begin @(negedge clk); n++; end
    vectors++;
    if (ce !== 1'b1 || write !== 1'b1 || address !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_mid_first_access: ce=%b wr=%b addr=%h want 1/1/0 soon after interval",
               ce, write, address);
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      mode[p] = 2'd0;
      ready_after[p] = 0;
      for (int b = 0; b < 4; b++) fbytes[p][b] = 8'h00;
    end
    test_reset();
    test_single_port();
    test_round_robin();
    test_dead_port();
    test_timeout();
`ifdef JOY_POLL_HOST_EN
    test_host_priority();
`endif
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
